airlock_sequencer: RTL and testbench



---
 rtl/airlock_sequencer_pkg.sv | 40 ++++
 rtl/airlock_sequencer_phase_timer.sv | 45 ++++
 rtl/airlock_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_airlock_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/airlock_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : airlock_pkg
// Description : Shared state encoding, default phase lengths and the counter
//               sizing helper for the airlock sequencer.
// Options     : AIRLOCK_ABORT_EN adds the ABORT_PRESS recovery state.
// Revision    : 1.0 - initial release
// ============================================================================
package airlock_pkg;

    // Default phase lengths, in ticks
    localparam int DEF_PRESS_TICKS   = 3;
    localparam int DEF_DEPRESS_TICKS = 2;
    localparam int DEF_DOOR_TICKS    = 4;
    localparam int DEF_CNT_W         = 8;

    // Sequencer states: A_* run an arrival, L_* run a departure
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        A_EVAC      = 4'd1,
        A_OUTER     = 4'd2,
        A_PRESS     = 4'd3,
        A_INNER     = 4'd4,
        L_INNER     = 4'd5,
        L_EVAC      = 4'd6,
        L_OUTER     = 4'd7,
        L_PRESS     = 4'd8
`ifdef AIRLOCK_ABORT_EN
        ,
        ABORT_PRESS = 4'd9
`endif
    } state_t;

    // Largest phase length a counter of width w can time
    function automatic int max_ticks(input int w);
        return (1 << w) - 1;
    endfunction

endpackage : airlock_pkg
`default_nettype wire

// File: rtl/airlock_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Tick-enabled phase counter. done pulses on the tick that
//               completes the limit-th tick since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Phase completes when the final tick of the phase arrives
    assign done = tick && (count_q == (limit - CNT_W'(1)));

    // Clear wins over counting so every phase starts from zero
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : phase_timer
`default_nettype wire

// File: rtl/airlock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : airlock_sequencer
// Description : Interlocked airlock cycle controller. Turns arrive/leave
//               request edges into pump and door sequences, buffering one
//               request per direction while a cycle is running.
// Options     : AIRLOCK_ABORT_EN adds abortReq and the ABORT_PRESS state.
// Revision    : 1.0 - initial release
// ============================================================================
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int PRESS_TICKS   = DEF_PRESS_TICKS,
    parameter int DEPRESS_TICKS = DEF_DEPRESS_TICKS,
    parameter int DOOR_TICKS    = DEF_DOOR_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic arriveSignal,
    input  logic leaveSignal,
`ifdef AIRLOCK_ABORT_EN
    input  logic abortReq,
`endif
    output logic outerPort,
    output logic innerPort,
    output logic pumpIn,
    output logic pumpOut,
    output logic pressurized,
    output logic busy
);

    // Reject phase lengths the counter cannot time
    if ((PRESS_TICKS < 1) || (DEPRESS_TICKS < 1) || (DOOR_TICKS < 1) ||
        (PRESS_TICKS   > max_ticks(CNT_W)) ||
        (DEPRESS_TICKS > max_ticks(CNT_W)) ||
        (DOOR_TICKS    > max_ticks(CNT_W))) begin : g_bad_ticks
        $error("airlock_sequencer: phase tick parameters out of range");
    end

    state_t state_q, state_d;
    logic   arrive_prev_q, leave_prev_q;
    logic   pend_arrive_q, pend_arrive_d;
    logic   pend_leave_q,  pend_leave_d;
    logic   press_q,       press_d;
    logic   outer_q, inner_q, pump_in_q, pump_out_q, busy_q;
    logic   outer_d, inner_d, pump_in_d, pump_out_d, busy_d;

    logic             w_arrive_edge;
    logic             w_leave_edge;
    logic             w_done;
    logic             w_clear;
    logic [CNT_W-1:0] w_limit;

`ifdef AIRLOCK_ABORT_EN
    logic abort_prev_q;
    logic abort_pend_q, abort_pend_d;
    logic w_abort_edge;
    assign w_abort_edge = abortReq & ~abort_prev_q;
`endif

    assign w_arrive_edge = arriveSignal & ~arrive_prev_q;
    assign w_leave_edge  = leaveSignal  & ~leave_prev_q;

    // Timer restarts on every state entry and is held cleared while idle
    assign w_clear = (state_d != state_q) || (state_q == IDLE);

    // Phase length for the current state
    always_comb begin
        w_limit = CNT_W'(DOOR_TICKS);
        case (state_q)
            A_EVAC, L_EVAC:   w_limit = CNT_W'(DEPRESS_TICKS);
            A_PRESS, L_PRESS: w_limit = CNT_W'(PRESS_TICKS);
`ifdef AIRLOCK_ABORT_EN
            ABORT_PRESS:      w_limit = CNT_W'(PRESS_TICKS);
`endif
            default:          w_limit = CNT_W'(DOOR_TICKS);
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (tick),
        .limit (w_limit),
        .done  (w_done)
    );

    // Next-state, request buffering and pressure bookkeeping
    always_comb begin
        state_d       = state_q;
        pend_arrive_d = pend_arrive_q;
        pend_leave_d  = pend_leave_q;
        press_d       = press_q;
`ifdef AIRLOCK_ABORT_EN
        abort_pend_d  = abort_pend_q;
`endif
        if (state_q == IDLE) begin
            // Dispatch does not wait for a tick; arrival has priority
            if (w_arrive_edge || pend_arrive_q) begin
                state_d       = A_EVAC;
                pend_arrive_d = 1'b0;
                if (w_leave_edge) begin
                    pend_leave_d = 1'b1;
                end
            end else if (w_leave_edge || pend_leave_q) begin
                state_d      = L_INNER;
                pend_leave_d = 1'b0;
            end
        end else begin
            // Buffer new requests; a second one while pending is dropped
            if (w_arrive_edge) begin
                pend_arrive_d = 1'b1;
            end
            if (w_leave_edge) begin
                pend_leave_d = 1'b1;
            end
`ifdef AIRLOCK_ABORT_EN
            // Door phases are never cut short; remember the abort
            if (w_abort_edge && (state_q == A_OUTER || state_q == A_INNER ||
                                 state_q == L_OUTER || state_q == L_INNER)) begin
                abort_pend_d = 1'b1;
            end
`endif
            if (w_done) begin
                case (state_q)
                    A_EVAC: begin
                        state_d = A_OUTER;
                        press_d = 1'b0;
                    end
                    A_OUTER: state_d = A_PRESS;
                    A_PRESS: begin
                        state_d = A_INNER;
                        press_d = 1'b1;
                    end
                    A_INNER: state_d = IDLE;
                    L_INNER: state_d = L_EVAC;
                    L_EVAC: begin
                        state_d = L_OUTER;
                        press_d = 1'b0;
                    end
                    L_OUTER: state_d = L_PRESS;
                    L_PRESS: begin
                        state_d = IDLE;
                        press_d = 1'b1;
                    end
`ifdef AIRLOCK_ABORT_EN
                    ABORT_PRESS: begin
                        state_d       = IDLE;
                        press_d       = 1'b1;
                        pend_arrive_d = 1'b0;
                        pend_leave_d  = 1'b0;
                    end
`endif
                    default: state_d = IDLE;
                endcase
`ifdef AIRLOCK_ABORT_EN
                // A latched door abort redirects the end of the door phase
                if ((abort_pend_q || w_abort_edge) &&
                    (state_q == A_OUTER || state_q == A_INNER ||
                     state_q == L_OUTER || state_q == L_INNER)) begin
                    state_d = ABORT_PRESS;
                end
`endif
            end
`ifdef AIRLOCK_ABORT_EN
            // Pump phases abort at once, even without a tick
            if (w_abort_edge && (state_q == A_EVAC || state_q == L_EVAC ||
                                 state_q == A_PRESS || state_q == L_PRESS)) begin
                state_d = ABORT_PRESS;
                if (state_q == A_EVAC || state_q == L_EVAC) begin
                    press_d = 1'b0;
                end
            end
`endif
        end
`ifdef AIRLOCK_ABORT_EN
        if (state_d == ABORT_PRESS || state_d == IDLE) begin
            abort_pend_d = 1'b0;
        end
`endif
    end

    // Moore outputs decoded from the next state so they leave a flop
    always_comb begin
        outer_d    = (state_d == A_OUTER) || (state_d == L_OUTER);
        inner_d    = (state_d == A_INNER) || (state_d == L_INNER);
        pump_out_d = (state_d == A_EVAC)  || (state_d == L_EVAC);
        pump_in_d  = (state_d == A_PRESS) || (state_d == L_PRESS);
`ifdef AIRLOCK_ABORT_EN
        pump_in_d  = pump_in_d || (state_d == ABORT_PRESS);
`endif
        busy_d     = (state_d != IDLE);
    end

    // State, request capture and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            arrive_prev_q <= 1'b0;
            leave_prev_q  <= 1'b0;
            pend_arrive_q <= 1'b0;
            pend_leave_q  <= 1'b0;
            press_q       <= 1'b1;
            outer_q       <= 1'b0;
            inner_q       <= 1'b0;
            pump_in_q     <= 1'b0;
            pump_out_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            arrive_prev_q <= arriveSignal;
            leave_prev_q  <= leaveSignal;
            pend_arrive_q <= pend_arrive_d;
            pend_leave_q  <= pend_leave_d;
            press_q       <= press_d;
            outer_q       <= outer_d;
            inner_q       <= inner_d;
            pump_in_q     <= pump_in_d;
            pump_out_q    <= pump_out_d;
            busy_q        <= busy_d;
        end
    end

`ifdef AIRLOCK_ABORT_EN
    // Abort edge detection and latched door abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_prev_q <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            abort_prev_q <= abortReq;
            abort_pend_q <= abort_pend_d;
        end
    end
`endif

    assign outerPort   = outer_q;
    assign innerPort   = inner_q;
    assign pumpIn      = pump_in_q;
    assign pumpOut     = pump_out_q;
    assign pressurized = press_q;
    assign busy        = busy_q;

    // Safety interlocks
    a_doors_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(outer_q && inner_q));
    a_pumps_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(pump_in_q && pump_out_q));
    a_outer_vacuum    : assert property (@(posedge clk) disable iff (rst)
        !(outer_q && press_q));
    a_inner_pressure  : assert property (@(posedge clk) disable iff (rst)
        !(inner_q && !press_q));

endmodule : airlock_sequencer
`default_nettype wire

// File: tb/tb_airlock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_airlock_sequencer
// Description : Directed self-checking bench for airlock_sequencer.
// Options     : AIRLOCK_ABORT_EN enables the abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_airlock_sequencer;

    // Observed vector: {outerPort, innerPort, pumpIn, pumpOut, pressurized, busy}
    localparam logic [5:0] C_IDLE  = 6'b000010;
    localparam logic [5:0] C_EVAC  = 6'b000111;
    localparam logic [5:0] C_OUTER = 6'b100001;
    localparam logic [5:0] C_PRESS = 6'b001001;
    localparam logic [5:0] C_INNER = 6'b010011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b1;
    logic arriveSignal = 1'b0;
    logic leaveSignal = 1'b0;
`ifdef AIRLOCK_ABORT_EN
    logic abortReq = 1'b0;
`endif
    logic outerPort, innerPort, pumpIn, pumpOut, pressurized, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_div = 1;

    airlock_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .arriveSignal (arriveSignal),
        .leaveSignal  (leaveSignal),
`ifdef AIRLOCK_ABORT_EN
        .abortReq     (abortReq),
`endif
        .outerPort    (outerPort),
        .innerPort    (innerPort),
        .pumpIn       (pumpIn),
        .pumpOut      (pumpOut),
        .pressurized  (pressurized),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Compare the output vector right now
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {outerPort, innerPort, pumpIn, pumpOut, pressurized, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Advance n cycles, checking each one mid-cycle, then drive tick for it
    task automatic expect_n(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            chk(tag, exp);
            tick = ((cyc % tick_div) == 0);
        end
    endtask

    task automatic expect_arrival(input string tag);
        expect_n({tag, "_evac"},  2, C_EVAC);
        expect_n({tag, "_outer"}, 4, C_OUTER);
        expect_n({tag, "_press"}, 3, C_PRESS);
        expect_n({tag, "_inner"}, 4, C_INNER);
    endtask

    task automatic expect_departure(input string tag);
        expect_n({tag, "_inner"}, 4, C_INNER);
        expect_n({tag, "_evac"},  2, C_EVAC);
        expect_n({tag, "_outer"}, 4, C_OUTER);
        expect_n({tag, "_press"}, 3, C_PRESS);
    endtask

    // Hard stop if the sequence ever stalls the bench
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        @(negedge clk);
        chk("reset", C_IDLE);
        rst = 1'b0;
        expect_n("post_reset", 2, C_IDLE);

        // Arrival; level stays high afterwards and must not retrigger
        cyc = 0;
        arriveSignal = 1'b1;
        expect_arrival("arr");
        expect_n("arr_done", 3, C_IDLE);

        // Departure with arrive still held high
        cyc = 0;
        leaveSignal = 1'b1;
        expect_departure("dep");
        expect_n("dep_done", 2, C_IDLE);
        arriveSignal = 1'b0;
        leaveSignal  = 1'b0;
        expect_n("drop1", 1, C_IDLE);

        // Simultaneous edges: arrival, one idle cycle, then departure
        cyc = 0;
        arriveSignal = 1'b1;
        leaveSignal  = 1'b1;
        expect_arrival("sim_a");
        expect_n("sim_gap", 1, C_IDLE);
        expect_departure("sim_l");
        expect_n("sim_done", 2, C_IDLE);
        arriveSignal = 1'b0;
        leaveSignal  = 1'b0;
        expect_n("drop2", 1, C_IDLE);

        // Two leave edges during an arrival give one departure
        cyc = 0;
        arriveSignal = 1'b1;
        expect_n("dup_evac", 2, C_EVAC);
        leaveSignal = 1'b1;
        expect_n("dup_outer_a", 2, C_OUTER);
        leaveSignal = 1'b0;
        expect_n("dup_outer_b", 1, C_OUTER);
        leaveSignal = 1'b1;
        expect_n("dup_outer_c", 1, C_OUTER);
        expect_n("dup_press", 3, C_PRESS);
        expect_n("dup_inner", 4, C_INNER);
        expect_n("dup_gap", 1, C_IDLE);
        expect_departure("dup_l");
        expect_n("dup_done", 3, C_IDLE);
        arriveSignal = 1'b0;
        leaveSignal  = 1'b0;
        expect_n("drop3", 1, C_IDLE);

        // Tick every 4th cycle: EVAC spans 8 cycles, then reset in OUTER
        cyc = 0;
        tick_div = 4;
        tick = 1'b1;
        arriveSignal = 1'b1;
        expect_n("slow_evac", 8, C_EVAC);
        expect_n("slow_outer", 5, C_OUTER);
        #2;
        rst = 1'b1;
        arriveSignal = 1'b0;
        #1;
        chk("reset_mid", C_IDLE);
        tick_div = 1;
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b1;
        expect_n("after_reset", 3, C_IDLE);

`ifdef AIRLOCK_ABORT_EN
        // Abort in EVAC: repressurize, drop the buffered departure
        cyc = 0;
        arriveSignal = 1'b1;
        expect_n("ab_evac", 1, C_EVAC);
        leaveSignal = 1'b1;
        abortReq    = 1'b1;
        expect_n("ab_press", 3, C_PRESS);
        expect_n("ab_done", 3, C_IDLE);
        arriveSignal = 1'b0;
        leaveSignal  = 1'b0;
        abortReq     = 1'b0;
        expect_n("ab_drop", 1, C_IDLE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_airlock_sequencer
`default_nettype wire
